// File: rtl/command_dispatch_and_collect.sv
// command_dispatch_and_collect: issues host config commands to target parsers and collects read responses
module command_dispatch_and_collect #(
  parameter int NUM_TGT     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_wr,
  input  logic                  i_cmd_rd,
  input  logic [18:0]           iv_cmd_addr,
  input  logic                  i_cmd_addr_fixed,
  input  logic [31:0]           iv_cmd_wdata,
  output logic                  o_cmd_ready,
  output logic [NUM_TGT-1:0]    ov_wr,
  output logic [NUM_TGT-1:0]    ov_rd,
  output logic [18:0]           ov_addr,
  output logic                  o_addr_fixed,
  output logic [31:0]           ov_wdata,
  input  logic [NUM_TGT-1:0]    iv_rsp_valid,
  input  logic [19*NUM_TGT-1:0] iv_rsp_addr,
  input  logic [32*NUM_TGT-1:0] iv_rsp_rdata,
  output logic                  o_rsp_valid,
  output logic [18:0]           ov_rsp_addr,
  output logic                  o_rsp_addr_fixed,
  output logic [31:0]           ov_rsp_rdata,
  output logic                  o_rsp_timeout,
  output logic                  o_rsp_unmapped
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, RESPOND} state_t;
  state_t state, state_d;
  logic [15:0] cnt;
  logic [15:0] cnt_inc;
  logic [2:0] idx;
  logic wr_q, to_q, um_q, mapped, match, sel_valid;
  logic [NUM_TGT-1:0] sel;
  logic [18:0] sel_addr;
  logic [31:0] sel_data;
  assign cnt_inc = cnt + 16'd1;
  assign mapped = 32'(idx) < NUM_TGT;
  // mux the selected target's response; an unmapped index selects nothing
  always_comb begin
    sel = '0;
    sel_valid = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_TGT; k++) begin
      if (32'(idx) == k) begin
        sel[k] = 1'b1;
        sel_valid = iv_rsp_valid[k];
        sel_addr = iv_rsp_addr[19*k +: 19];
        sel_data = iv_rsp_rdata[32*k +: 32];
      end
    end
  end
  assign match = sel_valid && sel_addr == ov_addr;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:     state_d = (i_cmd_wr | i_cmd_rd) ? ISSUE : IDLE;
      ISSUE:    state_d = wr_q ? IDLE : mapped ? WAIT_RSP : RESPOND;
      WAIT_RSP: state_d = (match || cnt_inc == 16'(TIMEOUT_CYC)) ? RESPOND : WAIT_RSP;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      wr_q <= 1'b0;
      ov_addr <= '0;
      o_addr_fixed <= 1'b0;
      ov_wdata <= '0;
      ov_rsp_addr <= '0;
      o_rsp_addr_fixed <= 1'b0;
      ov_rsp_rdata <= '0;
      to_q <= 1'b0;
      um_q <= 1'b0;
    end else begin
      state <= state_d;
      if (state == IDLE && (i_cmd_wr | i_cmd_rd)) begin
        ov_addr <= iv_cmd_addr;
        o_addr_fixed <= i_cmd_addr_fixed;
        ov_wdata <= iv_cmd_wdata;
        wr_q <= i_cmd_wr;
        idx <= iv_cmd_addr[18:16];
      end
      cnt <= state == WAIT_RSP ? cnt_inc : '0;
      if (state != RESPOND && state_d == RESPOND) begin
        ov_rsp_addr <= ov_addr;
        o_rsp_addr_fixed <= o_addr_fixed;
        ov_rsp_rdata <= (state == WAIT_RSP && match) ? sel_data : '0;
        to_q <= state == WAIT_RSP && !match;
        um_q <= state == ISSUE;
      end
    end
  end
  assign o_cmd_ready = state == IDLE;
  assign ov_wr = (state == ISSUE && wr_q) ? sel : '0;
  assign ov_rd = (state == ISSUE && !wr_q) ? sel : '0;
  assign o_rsp_valid = state == RESPOND;
  assign o_rsp_timeout = o_rsp_valid && to_q;
  assign o_rsp_unmapped = o_rsp_valid && um_q;
endmodule

// File: tb/tb_command_dispatch_and_collect.sv
// tb_command_dispatch_and_collect: directed vectors plus multi-cycle sequences for the command dispatcher
module tb_command_dispatch_and_collect;
  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_cmd_wr = 1'b0, i_cmd_rd = 1'b0, i_cmd_addr_fixed = 1'b0;
  logic [18:0] iv_cmd_addr = '0;
  logic [31:0] iv_cmd_wdata = '0;
  logic [3:0] iv_rsp_valid = '0;
  logic [75:0] iv_rsp_addr = '0;
  logic [127:0] iv_rsp_rdata = '0;
  logic rdy, afx, rv, rfx, rto, rum;
  logic [3:0] wr, rd;
  logic [18:0] addr, raddr;
  logic [31:0] wdata, rdata;
  logic rdy4, afx4, rv4, rfx4, rto4, rum4;
  logic [3:0] wr4, rd4;
  logic [18:0] addr4, raddr4;
  logic [31:0] wdata4, rdata4;
  int total = 0, bad = 0;

  always #5 i_clk = ~i_clk;

  command_dispatch_and_collect u_dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_wr(i_cmd_wr), .i_cmd_rd(i_cmd_rd),
    .iv_cmd_addr(iv_cmd_addr), .i_cmd_addr_fixed(i_cmd_addr_fixed), .iv_cmd_wdata(iv_cmd_wdata),
    .o_cmd_ready(rdy), .ov_wr(wr), .ov_rd(rd), .ov_addr(addr), .o_addr_fixed(afx), .ov_wdata(wdata),
    .iv_rsp_valid(iv_rsp_valid), .iv_rsp_addr(iv_rsp_addr), .iv_rsp_rdata(iv_rsp_rdata),
    .o_rsp_valid(rv), .ov_rsp_addr(raddr), .o_rsp_addr_fixed(rfx), .ov_rsp_rdata(rdata),
    .o_rsp_timeout(rto), .o_rsp_unmapped(rum));

  command_dispatch_and_collect #(.NUM_TGT(4), .TIMEOUT_CYC(4)) u_dut4 (
    .i_clk(i_clk), .i_rst(i_rst), .i_cmd_wr(i_cmd_wr), .i_cmd_rd(i_cmd_rd),
    .iv_cmd_addr(iv_cmd_addr), .i_cmd_addr_fixed(i_cmd_addr_fixed), .iv_cmd_wdata(iv_cmd_wdata),
    .o_cmd_ready(rdy4), .ov_wr(wr4), .ov_rd(rd4), .ov_addr(addr4), .o_addr_fixed(afx4), .ov_wdata(wdata4),
    .iv_rsp_valid(iv_rsp_valid), .iv_rsp_addr(iv_rsp_addr), .iv_rsp_rdata(iv_rsp_rdata),
    .o_rsp_valid(rv4), .ov_rsp_addr(raddr4), .o_rsp_addr_fixed(rfx4), .ov_rsp_rdata(rdata4),
    .o_rsp_timeout(rto4), .o_rsp_unmapped(rum4));

  typedef struct {
    logic wr, rd;
    logic [18:0] addr;
    logic fx;
    logic [31:0] wd;
    logic [3:0] ewr, erd;
    logic ersp;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic send(input logic w, input logic r, input logic [18:0] a, input logic fx, input logic [31:0] wd);
    i_cmd_wr = w;
    i_cmd_rd = r;
    iv_cmd_addr = a;
    i_cmd_addr_fixed = fx;
    iv_cmd_wdata = wd;
    step;
    i_cmd_wr = 1'b0;
    i_cmd_rd = 1'b0;
  endtask

  task automatic rsp(input int k, input logic [18:0] a, input logic [31:0] d);
    iv_rsp_valid[k] = 1'b1;
    iv_rsp_addr[19*k +: 19] = a;
    iv_rsp_rdata[32*k +: 32] = d;
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!(rdy && rdy4) && n < 400) begin
      step;
      n++;
    end
    chk("wait_ready", {62'd0, rdy, rdy4}, 64'd3);
  endtask

  initial begin
    int n;
    logic seen;
    tbl[0] = '{1'b1, 1'b0, 19'h1_0040, 1'b0, 32'hA5A5_0001, 4'b0010, 4'b0000, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 19'h3_1234, 1'b1, 32'hDEAD_BEEF, 4'b1000, 4'b0000, 1'b0};
    tbl[2] = '{1'b1, 1'b0, 19'h0_0001, 1'b0, 32'h0000_0003, 4'b0001, 4'b0000, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 19'h7_0000, 1'b0, 32'h0BAD_0BAD, 4'b0000, 4'b0000, 1'b0};
    tbl[4] = '{1'b1, 1'b1, 19'h2_0005, 1'b1, 32'h5555_AAAA, 4'b0100, 4'b0000, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 19'h7_0000, 1'b0, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 19'h4_0010, 1'b1, 32'h0000_0000, 4'b0000, 4'b0000, 1'b1};

    repeat (3) step;
    chk("rst_ready", 64'(rdy), 64'd1);
    chk("rst_wr", 64'(wr), 64'd0);
    chk("rst_rd", 64'(rd), 64'd0);
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_rsp_valid", 64'(rv), 64'd0);
    i_rst = 1'b0;
    step;

    for (int i = 0; i < 7; i++) begin
      send(tbl[i].wr, tbl[i].rd, tbl[i].addr, tbl[i].fx, tbl[i].wd);
      chk($sformatf("v%0d_wr", i), 64'(wr), 64'(tbl[i].ewr));
      chk($sformatf("v%0d_rd", i), 64'(rd), 64'(tbl[i].erd));
      chk($sformatf("v%0d_addr", i), 64'(addr), 64'(tbl[i].addr));
      chk($sformatf("v%0d_fixed", i), 64'(afx), 64'(tbl[i].fx));
      chk($sformatf("v%0d_wdata", i), 64'(wdata), 64'(tbl[i].wd));
      chk($sformatf("v%0d_busy", i), 64'(rdy), 64'd0);
      step;
      if (tbl[i].ersp) begin
        chk($sformatf("v%0d_rsp_valid", i), 64'(rv), 64'd1);
        chk($sformatf("v%0d_unmapped", i), 64'(rum), 64'd1);
        chk($sformatf("v%0d_timeout", i), 64'(rto), 64'd0);
        chk($sformatf("v%0d_rdata", i), 64'(rdata), 64'd0);
        chk($sformatf("v%0d_rsp_addr", i), 64'(raddr), 64'(tbl[i].addr));
        chk($sformatf("v%0d_rsp_fixed", i), 64'(rfx), 64'(tbl[i].fx));
        step;
      end
      chk($sformatf("v%0d_no_rsp", i), 64'(rv), 64'd0);
      chk($sformatf("v%0d_ready", i), 64'(rdy), 64'd1);
    end

    // read target 0, answered 3 cycles after the strobe; a host write while busy is ignored
    send(1'b0, 1'b1, 19'h0_0008, 1'b0, 32'h0);
    chk("rd0_strobe", 64'(rd), 64'd1);
    chk("rd0_wr", 64'(wr), 64'd0);
    step;
    i_cmd_wr = 1'b1;
    iv_cmd_addr = 19'h1_0000;
    chk("rd0_busy", 64'(rdy), 64'd0);
    step;
    i_cmd_wr = 1'b0;
    chk("busy_wr_ignored", 64'(wr), 64'd0);
    chk("busy_addr_held", 64'(addr), 64'h0_0008);
    step;
    rsp(0, 19'h0_0008, 32'h1234_5678);
    chk("rd0_early_valid", 64'(rv), 64'd0);
    step;
    iv_rsp_valid = '0;
    chk("rd0_rsp_valid", 64'(rv), 64'd1);
    chk("rd0_rdata", 64'(rdata), 64'h1234_5678);
    chk("rd0_timeout", 64'(rto), 64'd0);
    chk("rd0_rsp_addr", 64'(raddr), 64'h0_0008);
    step;
    chk("rd0_valid_1cyc", 64'(rv), 64'd0);
    chk("rd0_ready", 64'(rdy), 64'd1);
    wait_ready;

    // wrong-target and wrong-address responses are ignored until timeout
    send(1'b0, 1'b1, 19'h2_0000, 1'b0, 32'h0);
    chk("to_strobe", 64'(rd), 64'b0100);
    rsp(1, 19'h2_0000, 32'h1111_1111);
    rsp(2, 19'h2_0001, 32'h2222_2222);
    n = 0;
    while (!rv && n < 400) begin
      step;
      n++;
      if (n == 8) iv_rsp_valid = '0;
    end
    chk("to_latency", 64'(n), 64'd256);
    chk("to_flag", 64'(rto), 64'd1);
    chk("to_rdata", 64'(rdata), 64'd0);
    chk("to_unmapped", 64'(rum), 64'd0);
    step;
    wait_ready;

    // TIMEOUT_CYC=4: match on the limit cycle is data, silence is a timeout
    send(1'b0, 1'b1, 19'h1_0100, 1'b1, 32'h0);
    repeat (3) step;
    chk("lim_s3_valid", 64'(rv4), 64'd0);
    step;
    rsp(1, 19'h1_0100, 32'hCAFE_F00D);
    chk("lim_s4_valid", 64'(rv4), 64'd0);
    step;
    iv_rsp_valid = '0;
    chk("lim_valid", 64'(rv4), 64'd1);
    chk("lim_timeout", 64'(rto4), 64'd0);
    chk("lim_rdata", 64'(rdata4), 64'hCAFE_F00D);
    chk("lim_fixed", 64'(rfx4), 64'd1);
    step;
    wait_ready;
    send(1'b0, 1'b1, 19'h3_0000, 1'b0, 32'h0);
    repeat (4) step;
    chk("to4_s4_valid", 64'(rv4), 64'd0);
    step;
    chk("to4_valid", 64'(rv4), 64'd1);
    chk("to4_timeout", 64'(rto4), 64'd1);
    chk("to4_rdata", 64'(rdata4), 64'd0);
    step;
    wait_ready;

    // reset during WAIT_RSP aborts the read; a late response produces nothing
    send(1'b0, 1'b1, 19'h0_0020, 1'b1, 32'h0);
    step;
    step;
    i_rst = 1'b1;
    step;
    i_rst = 1'b0;
    chk("ab_ready", 64'(rdy), 64'd1);
    chk("ab_rd", 64'(rd), 64'd0);
    chk("ab_addr", 64'(addr), 64'd0);
    chk("ab_fixed", 64'(afx), 64'd0);
    chk("ab_rsp_addr", 64'(raddr), 64'd0);
    chk("ab_rsp_valid", 64'(rv), 64'd0);
    rsp(0, 19'h0_0020, 32'h7777_7777);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step;
      seen |= rv | rv4;
    end
    iv_rsp_valid = '0;
    chk("ab_late_rsp", 64'(seen), 64'd0);
    chk("ab_ready_after", 64'(rdy), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
